// File: rtl/lii_rr_arbiter.sv
// rtl/lii_rr_arbiter.sv - round-robin burst arbiter of NREQ LII streams onto one registered output
// Optional per-requester saturating beat counters on beat_cnt_o when LII_ARB_CNT_EN is defined.
module lii_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PW    = 64,
  parameter int BURST = 8
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [NREQ*PW-1:0] req_tdata,
  input  logic [NREQ-1:0]   req_tvalid,
  output logic [NREQ-1:0]   req_tready,
  input  logic [NREQ*8-1:0] req_src,
  input  logic [NREQ*8-1:0] req_dst,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst,
  output logic [NREQ-1:0]   grant_o
`ifdef LII_ARB_CNT_EN
  ,
  output logic [NREQ*32-1:0] beat_cnt_o
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [PW-1:0]   data_q, data_d;
  logic [7:0]      src_q, src_d;
  logic [7:0]      dst_q, dst_d;
  logic            valid_q, valid_d;

  logic [IW-1:0]   gidx;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   scan_idx;
  logic            found;
  logic            out_en;
  logic            accept;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gidx = IW'(i);
    end
  end

  // Scan starts one past the last served requester so the previous owner is checked last.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((int'(last_q) + k) % NREQ);
      if (!found && req_tvalid[scan_idx]) begin
        sel   = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign out_en     = !valid_q || lii_out_p0_tready;
  assign accept     = (state_q == GRANT) && out_en && req_tvalid[gidx];
  assign req_tready = ((state_q == GRANT) && out_en) ? grant_q : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    src_d   = src_q;
    dst_d   = dst_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = NREQ'(1) << sel;
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(BURST - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx;
          end
        end else if (out_en) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx;
        end
      end
      default: state_d = IDLE;
    endcase
    // Output register only moves when it is empty or being drained this cycle.
    if (out_en) begin
      valid_d = accept;
      if (accept) begin
        data_d = req_tdata[gidx*PW +: PW];
        src_d  = req_src[gidx*8 +: 8];
        dst_d  = req_dst[gidx*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= 8'd0;
      data_q  <= '0;
      src_q   <= 8'd0;
      dst_q   <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o           = grant_q;
  assign lii_out_p0_tdata  = data_q;
  assign lii_out_p0_src    = src_q;
  assign lii_out_p0_dst    = dst_q;
  assign lii_out_p0_tvalid = valid_q;

`ifdef LII_ARB_CNT_EN
  logic [31:0] bcnt_q [NREQ];

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NREQ; i++) bcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept && grant_q[i] && (bcnt_q[i] != 32'hFFFF_FFFF)) bcnt_q[i] <= bcnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    beat_cnt_o = '0;
    for (int i = 0; i < NREQ; i++) beat_cnt_o[i*32 +: 32] = bcnt_q[i];
  end
`endif

endmodule

// File: tb/tb_lii_rr_arbiter.sv
// tb/tb_lii_rr_arbiter.sv - scoreboard bench for lii_rr_arbiter (fairness, early release, backpressure, reset)
module tb_lii_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int PW    = 64;
  localparam int BURST = 8;

  logic               aclk = 1'b0;
  logic               arst = 1'b1;
  logic [NREQ*PW-1:0] req_tdata = '0;
  logic [NREQ-1:0]    req_tvalid = '0;
  logic [NREQ-1:0]    req_tready;
  logic [NREQ*8-1:0]  req_src = '0;
  logic [NREQ*8-1:0]  req_dst = '0;
  logic [PW-1:0]      lii_out_p0_tdata;
  logic               lii_out_p0_tvalid;
  logic               lii_out_p0_tready = 1'b1;
  logic [7:0]         lii_out_p0_src;
  logic [7:0]         lii_out_p0_dst;
  logic [NREQ-1:0]    grant_o;
`ifdef LII_ARB_CNT_EN
  logic [NREQ*32-1:0] beat_cnt_o;
`endif

  always #5 aclk = ~aclk;

  lii_rr_arbiter #(.NREQ(NREQ), .PW(PW), .BURST(BURST)) dut (
    .aclk              (aclk),
    .arst              (arst),
    .req_tdata         (req_tdata),
    .req_tvalid        (req_tvalid),
    .req_tready        (req_tready),
    .req_src           (req_src),
    .req_dst           (req_dst),
    .lii_out_p0_tdata  (lii_out_p0_tdata),
    .lii_out_p0_tvalid (lii_out_p0_tvalid),
    .lii_out_p0_tready (lii_out_p0_tready),
    .lii_out_p0_src    (lii_out_p0_src),
    .lii_out_p0_dst    (lii_out_p0_dst),
`ifdef LII_ARB_CNT_EN
    .beat_cnt_o        (beat_cnt_o),
`endif
    .grant_o           (grant_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          idle_cnt = 0;
  logic        out_rdy  = 1'b1;
  logic [79:0] rq [NREQ][$];
  logic [79:0] exp_q [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat layout {src, dst, data}; data encodes requester and sequence number.
  function automatic logic [79:0] mk(input int r, input int k);
    return {8'(16 + r), 8'(32 + r), 32'(r), 32'(k)};
  endfunction

  task automatic add(input int r, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) rq[r].push_back(mk(r, k));
  endtask

  task automatic expect_beats(input int r, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) exp_q.push_back(mk(r, k));
  endtask

  task automatic cycle();
    logic [79:0] h;
    logic        busy;
    @(negedge aclk);
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        req_tvalid[i]          = 1'b1;
        req_tdata[i*PW +: PW]  = h[63:0];
        req_dst[i*8 +: 8]      = h[71:64];
        req_src[i*8 +: 8]      = h[79:72];
      end else begin
        req_tvalid[i] = 1'b0;
      end
    end
    lii_out_p0_tready = out_rdy;
    #1;
    busy = 1'b0;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) busy = 1'b1;
    if (busy && grant_o == '0) idle_cnt++;
    chk("grant_onehot", 128'($onehot0(grant_o)), 128'(1));
    if (lii_out_p0_tvalid && lii_out_p0_tready) begin
      if (exp_q.size() == 0) chk("extra_beat", 128'(exp_q.size()), 128'(1));
      else chk("out_beat", 128'({lii_out_p0_src, lii_out_p0_dst, lii_out_p0_tdata}), 128'(exp_q.pop_front()));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_tvalid[i] && req_tready[i]) begin
        chk("tready_grant", 128'(grant_o), 128'(1) << i);
        void'(rq[i].pop_front());
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tvalid"}, 128'(lii_out_p0_tvalid), 128'(0));
    chk({tag, "_tdata"}, 128'(lii_out_p0_tdata), 128'(0));
    chk({tag, "_srcdst"}, 128'({lii_out_p0_src, lii_out_p0_dst}), 128'(0));
    chk({tag, "_grant"}, 128'(grant_o), 128'(0));
    chk({tag, "_tready"}, 128'(req_tready), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge aclk);
    arst = 1'b1;
    #1;
    chk_zero_outputs("reset");
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    req_tvalid = '0;
    @(negedge aclk);
    arst = 1'b0;
  endtask

  initial begin
    #1;
    chk_zero_outputs("por");
    @(negedge aclk);
    arst = 1'b0;

    // Fairness: all four valid for two rounds of full bursts.
    idle_cnt = 0;
    for (int r = 0; r < NREQ; r++) add(r, 0, 2 * BURST);
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < NREQ; r++) expect_beats(r, rnd * BURST, BURST);
    drain(300);
    chk("fair_idle_cycles", 128'(idle_cnt), 128'(2 * NREQ));

    // Early release: requester 2 alone for 3 beats, then 3 and 0 compete.
    idle_cnt = 0;
    add(2, 100, 3);
    expect_beats(2, 100, 3);
    cycle();
    add(3, 100, 2);
    add(0, 100, 2);
    expect_beats(3, 100, 2);
    expect_beats(0, 100, 2);
    drain(100);
    chk("early_idle_cycles", 128'(idle_cnt), 128'(3));

    // Backpressure mid-burst; 10 beats also forces a burst-exhaust re-grant of the sole requester.
    idle_cnt = 0;
    add(1, 200, 10);
    expect_beats(1, 200, 10);
    repeat (4) cycle();
    out_rdy = 1'b0;
    for (int s = 0; s < 20; s++) begin
      cycle();
      chk("stall_tvalid", 128'(lii_out_p0_tvalid), 128'(1));
      chk("stall_beat", 128'({lii_out_p0_src, lii_out_p0_dst, lii_out_p0_tdata}), 128'(exp_q[0]));
      chk("stall_grant", 128'(grant_o), 128'(4'b0010));
      chk("stall_tready", 128'(req_tready), 128'(0));
    end
    out_rdy = 1'b1;
    drain(100);
    chk("bp_idle_cycles", 128'(idle_cnt), 128'(2));

    // Reset mid-burst from requester 3, then first grant must go to requester 0.
    add(3, 300, 8);
    expect_beats(3, 300, 8);
    repeat (4) cycle();
    chk("pre_reset_tvalid", 128'(lii_out_p0_tvalid), 128'(1));
    do_reset();
    idle_cnt = 0;
    add(0, 400, 3);
    add(3, 400, 3);
    expect_beats(0, 400, 3);
    expect_beats(3, 400, 3);
    drain(100);
    chk("post_reset_idle", 128'(idle_cnt), 128'(2));

`ifdef LII_ARB_CNT_EN
    do_reset();
    add(1, 500, 100);
    expect_beats(1, 500, 100);
    drain(400);
    chk("beat_cnt", 128'(beat_cnt_o), 128'({32'd0, 32'd0, 32'd100, 32'd0}));
`endif

    repeat (3) cycle();
    chk("final_idle_grant", 128'(grant_o), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
